trace_capture_buffer: RTL and testbench
=======================================

Name: trace_capture_buffer

Overview:
- Synthesizable on-chip trace unit for the pipelined CPU: records per-cycle commit state (pc, instr, register write-back) into a circular buffer.
- Supports arm/trigger/post-trigger capture, then drains the records oldest-first over a valid/ready port.
- Sits beside the pipeline and taps the IF/WB signals. Lets silicon/FPGA runs produce the same per-cycle log that simulation benches print.

Parameters:
- DATA_W, 32, width of pc, instr and write-back data.
- DEPTH, 16, buffer entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).
- CAPTURE_STALLS, 0, 1 = record stalled cycles too; 0 = record only cycles with stall_i=0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- pc_i  in  DATA_W  current pc.
- instr_i  in  DATA_W  current instruction.
- stall_i  in  1  pipeline stall.
- wb_en_i  in  1  register-file write enable.
- wb_addr_i  in  5  register-file write address.
- wb_data_i  in  DATA_W  register-file write data.
- arm_i  in  1  start capture (pulse).
- abort_i  in  1  cancel capture or readout (pulse).
- trig_mode_i  in  2  0 immediate, 1 pc match, 2 instr match, 3 wb_addr match with wb_en_i.
- trig_value_i  in  DATA_W  compare value; low 5 bits used in mode 3.
- post_count_i  in  PTR_W+1  records to capture after the trigger record.
- rd_ready_i  in  1  consumer ready.
- rd_valid_o  out  1  record available.
- rd_data_o  out  3*DATA_W+6  {pc, instr, wb_en, wb_addr, wb_data}.
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- count_o  out  PTR_W+1  valid records held.
- wrapped_o  out  1  at least one record was overwritten since arm.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, count_o 0, wrapped_o 0, rd_valid_o 0, rd_data_o 0, pointers 0. Storage contents are don't-care.
- Qualified cycle: stall_i=0, or CAPTURE_STALLS=1.
- IDLE:
  - arm_i=1 clears count, pointers and wrapped_o.
  - Latches trig_mode_i and trig_value_i.
  - Latches post = min(post_count_i, DEPTH-1).
  - Next state ARMED. No capture happens on the arm cycle.
- ARMED:
  - Each qualified cycle writes a record at wr_ptr, then wr_ptr+1 (mod DEPTH).
  - If count==DEPTH, the oldest record is overwritten: rd_ptr+1 and wrapped_o=1; count holds at DEPTH. Otherwise count+1.
  - Trigger fires only on a qualified cycle where the mode matches; mode 0 fires on the first qualified cycle.
  - The trigger record is written in that same cycle.
  - Next state POST if post>0, else DONE.
- POST: each qualified cycle writes a record with the same wrap rules and decrements post. The write that makes post reach 0 moves to DONE.
- Trigger record is never overwritten, because post is clamped to DEPTH-1.
- DONE:
  - rd_valid_o = (count_o != 0).
  - rd_data_o = mem[rd_ptr] (combinational read).
  - rd_valid_o & rd_ready_i: rd_ptr+1, count-1. The transfer of the last record returns to IDLE.
  - DONE with count 0 returns to IDLE next cycle.
- Latency: capture 1 cycle (input at edge N is readable after edge N+1). Readout delivers 1 record per cycle under continuous ready.
- abort_i in any state: next state IDLE, count 0, rd_valid_o 0. abort_i has priority over arm_i, trigger and read.
- arm_i outside IDLE is ignored. Inputs are ignored in DONE; no capture happens.
- rd_ready_i outside DONE is ignored. rd_data_o must hold stable while rd_valid_o=1 and rd_ready_i=0.
- Reset mid-capture or mid-readout: full reset as above, no partial records emitted.

Decomposition:
- Package trace_pkg:
  - state encoding and trig_mode encodings;
  - record field offsets and REC_W(DATA_W) = 3*DATA_W+6;
  - pack/unpack functions.
- Sub-module trace_ram: DEPTH x REC_W storage, one synchronous write port, one asynchronous read port, no reset on storage.
- FSM, pointers and trigger compare live in the top.

Test Plan:
- Immediate mode, DEPTH=16, post_count_i=3, pc 0x00,0x04,... no stalls -> 4 records pc 0x00..0x0C, state DONE, count_o 4, wrapped_o 0. Drain with rd_ready_i=1 yields 4 beats then IDLE.
- PC trigger 0x40, post 2, DEPTH=16, pc incrementing by 4 from 0 -> count_o 16, wrapped_o 1, first record pc 0x0C, last 0x48, trigger record 0x40 at index 13.
- Stall filtering, CAPTURE_STALLS=0: stall_i high on pcs 0x08,0x0C, immediate mode, post 5 -> records exclude the stalled cycles: 0x00,0x04,0x10,0x14,0x18,0x1C.
- Mode 3, trig_value_i=5, wb_en_i=1 wb_addr_i=5 wb_data_i=0xDEADBEEF at pc 0x20, post 0 -> DONE immediately; last record {0x20, instr, 1, 5, 0xDEADBEEF}.
- Backpressure: toggle rd_ready_i 1,0,0,1 in DONE -> rd_data_o stable while stalled, no duplicate or lost record, count decrements only on handshake.
- abort_i during POST with count 7, and rst=0 during readout -> IDLE next cycle, count_o 0, rd_valid_o 0; a fresh arm then works normally.

Source files
------------

// File: rtl/trace_pkg.sv
// ============================================================================
// trace_pkg : state/trigger encodings and record layout for the trace buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package trace_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] TRIG_IMM   = 2'd0;
  localparam logic [1:0] TRIG_PC    = 2'd1;
  localparam logic [1:0] TRIG_INSTR = 2'd2;
  localparam logic [1:0] TRIG_WB    = 2'd3;

  // Pack/unpack operate on a maximal record; callers cast to REC_W (DATA_W <= 64).
  localparam int MAX_DATA_W  = 64;
  localparam int MAX_REC_W   = 3*MAX_DATA_W+6;
  localparam int OFF_WB_DATA = 0;

  typedef logic [MAX_REC_W-1:0] rec_max_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] pc;
    logic [MAX_DATA_W-1:0] instr;
    logic                  wb_en;
    logic [4:0]            wb_addr;
    logic [MAX_DATA_W-1:0] wb_data;
  } rec_fields_t;

  function automatic int rec_w(int dw);
    return 3*dw+6;
  endfunction

  function automatic int off_wb_addr(int dw);
    return dw;
  endfunction

  function automatic int off_wb_en(int dw);
    return dw+5;
  endfunction

  function automatic int off_instr(int dw);
    return dw+6;
  endfunction

  function automatic int off_pc(int dw);
    return 2*dw+6;
  endfunction

  function automatic rec_max_t pack(int dw, logic [MAX_DATA_W-1:0] pc,
                                    logic [MAX_DATA_W-1:0] instr, logic wb_en,
                                    logic [4:0] wb_addr, logic [MAX_DATA_W-1:0] wb_data);
    rec_max_t r;
    r = rec_max_t'(wb_data) << OFF_WB_DATA;
    r = r | (rec_max_t'(wb_addr) << off_wb_addr(dw));
    r = r | (rec_max_t'(wb_en)   << off_wb_en(dw));
    r = r | (rec_max_t'(instr)   << off_instr(dw));
    r = r | (rec_max_t'(pc)      << off_pc(dw));
    return r;
  endfunction

  function automatic rec_fields_t unpack(int dw, rec_max_t rec);
    rec_fields_t           u;
    logic [MAX_DATA_W-1:0] m;
    m         = (64'd1 << dw) - 64'd1;
    u.wb_data = 64'(rec >> OFF_WB_DATA) & m;
    u.wb_addr = 5'(rec >> off_wb_addr(dw));
    u.wb_en   = rec[off_wb_en(dw)];
    u.instr   = 64'(rec >> off_instr(dw)) & m;
    u.pc      = 64'(rec >> off_pc(dw)) & m;
    return u;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================================
// trace_ram : DEPTH x WIDTH storage, synchronous write, asynchronous read
// Rev 1.0
// ============================================================================
`default_nettype none

module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 102,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/trace_capture_buffer.sv
// ============================================================================
// trace_capture_buffer : arm/trigger/post-trigger commit trace, drained oldest-first
// Rev 1.0
// ============================================================================
`default_nettype none

module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 16,
  parameter int PTR_W          = $clog2(DEPTH),
  parameter int CAPTURE_STALLS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     pc_i,
  input  logic [DATA_W-1:0]     instr_i,
  input  logic                  stall_i,
  input  logic                  wb_en_i,
  input  logic [4:0]            wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [1:0]            trig_mode_i,
  input  logic [DATA_W-1:0]     trig_value_i,
  input  logic [PTR_W:0]        post_count_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [3*DATA_W+5:0]   rd_data_o,
  output logic [1:0]            state_o,
  output logic [PTR_W:0]        count_o,
  output logic                  wrapped_o
);

  localparam int REC_W = rec_w(DATA_W);
  localparam int CNT_W = PTR_W+1;
  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_post_max = CNT_W'(DEPTH-1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_post;
  logic              r_wrapped;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_value;

  logic              w_qual;
  logic              w_match;
  logic              w_capture;
  logic              w_pop;
  logic [REC_W-1:0]  w_rec;
  logic [REC_W-1:0]  w_rd_rec;

  assign w_qual = !stall_i || (CAPTURE_STALLS != 0);

  always_comb begin
    w_match = 1'b0;
    case (r_mode)
      TRIG_IMM:   w_match = 1'b1;
      TRIG_PC:    w_match = (pc_i == r_value);
      TRIG_INSTR: w_match = (instr_i == r_value);
      default:    w_match = wb_en_i && (wb_addr_i == r_value[4:0]);
    endcase
  end

  assign w_capture = w_qual && !abort_i && (r_state == ST_ARMED || r_state == ST_POST);
  assign w_pop     = (r_state == ST_DONE) && (r_count != '0) && rd_ready_i && !abort_i;

  assign w_rec = REC_W'(pack(DATA_W, 64'(pc_i), 64'(instr_i), wb_en_i, wb_addr_i, 64'(wb_data_i)));

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_capture),
    .waddr (r_wr_ptr),
    .wdata (w_rec),
    .raddr (r_rd_ptr),
    .rdata (w_rd_rec)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort_i) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (arm_i) w_next_state = ST_ARMED;
        ST_ARMED: if (w_qual && w_match) w_next_state = (r_post != '0) ? ST_POST : ST_DONE;
        ST_POST:  if (w_qual && r_post == CNT_W'(1)) w_next_state = ST_DONE;
        default: begin
          if (r_count == '0 || (w_pop && r_count == CNT_W'(1))) w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_valid_o = 1'b0;
    rd_data_o  = '0;
    if (r_state == ST_DONE && r_count != '0) begin
      rd_valid_o = 1'b1;
      rd_data_o  = w_rd_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_post    <= '0;
      r_wrapped <= 1'b0;
      r_mode    <= TRIG_IMM;
      r_value   <= '0;
    end else if (abort_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (arm_i) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_wrapped <= 1'b0;
        r_mode    <= trig_mode_i;
        r_value   <= trig_value_i;
        r_post    <= (post_count_i > c_post_max) ? c_post_max : post_count_i;
      end
    end else if (w_capture) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      // A full buffer drops its oldest record so the window always ends at the newest
      if (r_count == c_depth) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_wrapped <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
      if (r_state == ST_POST) r_post <= r_post - CNT_W'(1);
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count  <= r_count - CNT_W'(1);
    end
  end

  assign state_o   = r_state;
  assign count_o   = r_count;
  assign wrapped_o = r_wrapped;

endmodule

`default_nettype wire

// File: tb/tb_trace_capture_buffer.sv
// ============================================================================
// tb_trace_capture_buffer : directed self-checking bench for trace_capture_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_trace_capture_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  pc_i = '0, instr_i = '0, wb_data_i = '0, trig_value_i = '0;
  logic         stall_i = 1'b0, wb_en_i = 1'b0, arm_i = 1'b0, abort_i = 1'b0, rd_ready_i = 1'b0;
  logic [4:0]   wb_addr_i = '0;
  logic [1:0]   trig_mode_i = '0;
  logic [4:0]   post_count_i = '0;
  logic         rd_valid_o;
  logic [101:0] rd_data_o;
  logic [1:0]   state_o;
  logic [4:0]   count_o;
  logic         wrapped_o;

  int tests_run    = 0;
  int tests_failed = 0;

  trace_capture_buffer #(
    .DATA_W(32), .DEPTH(16), .CAPTURE_STALLS(0)
  ) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .instr_i(instr_i), .stall_i(stall_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .arm_i(arm_i), .abort_i(abort_i), .trig_mode_i(trig_mode_i),
    .trig_value_i(trig_value_i), .post_count_i(post_count_i),
    .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .state_o(state_o), .count_o(count_o), .wrapped_o(wrapped_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [1:0] mode, input logic [31:0] value, input logic [4:0] post);
    arm_i = 1'b1; trig_mode_i = mode; trig_value_i = value; post_count_i = post;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic feed(input logic [31:0] pc, input logic stall);
    pc_i    = pc;
    instr_i = {16'hA5A5, pc[15:0]};
    stall_i = stall;
    tick();
    stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    tests_run++;
    if (state_o !== 2'd0 || count_o !== 5'd0 || wrapped_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== '0) begin
      tests_failed++;
      $display("FAIL reset: state=%0d count=%0d wrapped=%0b valid=%0b data=%h, expected 0/0/0/0/0",
               state_o, count_o, wrapped_o, rd_valid_o, rd_data_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_immediate();
    logic [31:0] exp;
    arm(2'd0, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) feed(32'(4*i), 1'b0);
    tests_run++;
    if (state_o !== 2'd3 || count_o !== 5'd4 || wrapped_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL imm_done: state=%0d count=%0d wrapped=%0b, expected 3/4/0", state_o, count_o, wrapped_o);
    end
    feed(32'h10, 1'b0);
    tests_run++;
    if (count_o !== 5'd4) begin
      tests_failed++;
      $display("FAIL imm_done_ignores_input: count=%0d, expected 4", count_o);
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'(4*i);
      tests_run++;
      if (rd_valid_o !== 1'b1 || rd_data_o[101:70] !== exp || rd_data_o[69:38] !== {16'hA5A5, exp[15:0]}) begin
        tests_failed++;
        $display("FAIL imm_drain[%0d]: valid=%0b pc=%h instr=%h, expected valid 1 pc %h", i, rd_valid_o,
                 rd_data_o[101:70], rd_data_o[69:38], exp);
      end
      tick();
    end
    rd_ready_i = 1'b0;
    tests_run++;
    if (state_o !== 2'd0 || rd_valid_o !== 1'b0 || count_o !== 5'd0) begin
      tests_failed++;
      $display("FAIL imm_idle: state=%0d valid=%0b count=%0d, expected 0/0/0", state_o, rd_valid_o, count_o);
    end
  endtask

  task automatic test_pc_trigger();
    logic [31:0] exp;
    arm(2'd1, 32'h40, 5'd2);
    for (int i = 0; i <= 18; i++) feed(32'(4*i), 1'b0);
    tests_run++;
    if (state_o !== 2'd3 || count_o !== 5'd16 || wrapped_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL pc_trig_done: state=%0d count=%0d wrapped=%0b, expected 3/16/1", state_o, count_o, wrapped_o);
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = 32'h0C + 32'(4*i);
      tests_run++;
      if (rd_valid_o !== 1'b1 || rd_data_o[101:70] !== exp) begin
        tests_failed++;
        $display("FAIL pc_trig_drain[%0d]: valid=%0b pc=%h, expected valid 1 pc %h", i, rd_valid_o, rd_data_o[101:70], exp);
      end
      tick();
    end
    rd_ready_i = 1'b0;
    tests_run++;
    if (state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL pc_trig_idle: state=%0d, expected 0", state_o);
    end
  endtask

  task automatic test_stall_filter();
    logic [31:0] exp_pc [6];
    exp_pc = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C};
    arm(2'd0, 32'h0, 5'd5);
    for (int i = 0; i < 8; i++) feed(32'(4*i), (i == 2 || i == 3));
    tests_run++;
    if (state_o !== 2'd3 || count_o !== 5'd6) begin
      tests_failed++;
      $display("FAIL stall_done: state=%0d count=%0d, expected 3/6", state_o, count_o);
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (rd_valid_o !== 1'b1 || rd_data_o[101:70] !== exp_pc[i]) begin
        tests_failed++;
        $display("FAIL stall_drain[%0d]: valid=%0b pc=%h, expected valid 1 pc %h", i, rd_valid_o, rd_data_o[101:70], exp_pc[i]);
      end
      tick();
    end
    rd_ready_i = 1'b0;
  endtask

  task automatic test_wb_trigger();
    logic [101:0] exp_rec;
    arm(2'd3, 32'h5, 5'd0);
    wb_en_i = 1'b1; wb_addr_i = 5'd3; feed(32'h10, 1'b0);
    wb_en_i = 1'b0; wb_addr_i = 5'd5; feed(32'h14, 1'b0);
    feed(32'h18, 1'b0);
    feed(32'h1C, 1'b0);
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    feed(32'h20, 1'b0);
    wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'h0;
    tests_run++;
    if (state_o !== 2'd3 || count_o !== 5'd5) begin
      tests_failed++;
      $display("FAIL wb_done: state=%0d count=%0d, expected 3/5", state_o, count_o);
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    exp_rec = {32'h20, 32'hA5A5_0020, 1'b1, 5'd5, 32'hDEADBEEF};
    tests_run++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_rec) begin
      tests_failed++;
      $display("FAIL wb_last_record: valid=%0b data=%h, expected valid 1 data %h", rd_valid_o, rd_data_o, exp_rec);
    end
    tick();
    rd_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    arm(2'd0, 32'h0, 5'd2);
    feed(32'h100, 1'b0); feed(32'h104, 1'b0); feed(32'h108, 1'b0);
    rd_ready_i = 1'b1;
    tests_run++;
    if (rd_valid_o !== 1'b1 || rd_data_o[101:70] !== 32'h100 || count_o !== 5'd3) begin
      tests_failed++;
      $display("FAIL bp_first: valid=%0b pc=%h count=%0d, expected 1/100/3", rd_valid_o, rd_data_o[101:70], count_o);
    end
    tick();
    rd_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (rd_valid_o !== 1'b1 || rd_data_o[101:70] !== 32'h104 || count_o !== 5'd2) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%0b pc=%h count=%0d, expected 1/104/2", i, rd_valid_o, rd_data_o[101:70], count_o);
      end
    end
    rd_ready_i = 1'b1;
    tick();
    tests_run++;
    if (rd_valid_o !== 1'b1 || rd_data_o[101:70] !== 32'h108 || count_o !== 5'd1) begin
      tests_failed++;
      $display("FAIL bp_resume: valid=%0b pc=%h count=%0d, expected 1/108/1", rd_valid_o, rd_data_o[101:70], count_o);
    end
    tick();
    rd_ready_i = 1'b0;
    tests_run++;
    if (state_o !== 2'd0 || count_o !== 5'd0) begin
      tests_failed++;
      $display("FAIL bp_idle: state=%0d count=%0d, expected 0/0", state_o, count_o);
    end
  endtask

  task automatic test_post_clamp();
    arm(2'd0, 32'h0, 5'd16);
    for (int i = 0; i < 16; i++) feed(32'h600 + 32'(4*i), 1'b0);
    tests_run++;
    if (state_o !== 2'd3 || count_o !== 5'd16 || wrapped_o !== 1'b0 || rd_data_o[101:70] !== 32'h600) begin
      tests_failed++;
      $display("FAIL post_clamp: state=%0d count=%0d wrapped=%0b pc=%h, expected 3/16/0/600",
               state_o, count_o, wrapped_o, rd_data_o[101:70]);
    end
    abort_i = 1'b1; tick(); abort_i = 1'b0;
  endtask

  task automatic test_abort();
    arm(2'd0, 32'h0, 5'd10);
    for (int i = 0; i < 7; i++) feed(32'h200 + 32'(4*i), 1'b0);
    tests_run++;
    if (state_o !== 2'd2 || count_o !== 5'd7) begin
      tests_failed++;
      $display("FAIL abort_pre: state=%0d count=%0d, expected 2/7", state_o, count_o);
    end
    abort_i = 1'b1; arm_i = 1'b1;
    tick();
    abort_i = 1'b0; arm_i = 1'b0;
    tests_run++;
    if (state_o !== 2'd0 || count_o !== 5'd0 || rd_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_post: state=%0d count=%0d valid=%0b, expected 0/0/0", state_o, count_o, rd_valid_o);
    end
    arm(2'd0, 32'h0, 5'd1);
    feed(32'h300, 1'b0); feed(32'h304, 1'b0);
    tests_run++;
    if (state_o !== 2'd3 || count_o !== 5'd2 || rd_data_o[101:70] !== 32'h300) begin
      tests_failed++;
      $display("FAIL abort_rearm: state=%0d count=%0d pc=%h, expected 3/2/300", state_o, count_o, rd_data_o[101:70]);
    end
    rd_ready_i = 1'b1; tick(); tick(); rd_ready_i = 1'b0;
  endtask

  task automatic test_reset_readout();
    arm(2'd0, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) feed(32'h400 + 32'(4*i), 1'b0);
    rd_ready_i = 1'b1; tick();
    rst = 1'b0; tick(); rst = 1'b1; rd_ready_i = 1'b0;
    tests_run++;
    if (state_o !== 2'd0 || count_o !== 5'd0 || rd_valid_o !== 1'b0 || wrapped_o !== 1'b0 || rd_data_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_readout: state=%0d count=%0d valid=%0b wrapped=%0b data=%h, expected all 0",
               state_o, count_o, rd_valid_o, wrapped_o, rd_data_o);
    end
    arm(2'd0, 32'h0, 5'd0);
    feed(32'h500, 1'b0);
    tests_run++;
    if (state_o !== 2'd3 || count_o !== 5'd1 || rd_valid_o !== 1'b1 || rd_data_o[101:70] !== 32'h500) begin
      tests_failed++;
      $display("FAIL reset_rearm: state=%0d count=%0d valid=%0b pc=%h, expected 3/1/1/500",
               state_o, count_o, rd_valid_o, rd_data_o[101:70]);
    end
    rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
    tests_run++;
    if (state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_rearm_idle: state=%0d, expected 0", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_pc_trigger();
    test_stall_filter();
    test_wb_trigger();
    test_backpressure();
    test_post_clamp();
    test_abort();
    test_reset_readout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
